// File: rtl/mux_rr_arbiter_if.sv
// rtl/mux_rr_arbiter_if.sv - request/grant/select bundle between requesters, arbiter and 4:1 mux
interface mux_rr_arbiter_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       s0;
  logic       s1;
  logic       busy;

  // Arbiter side: consumes requests, produces grant and mux selects
  modport master (
    input  req,
    output gnt,
    output s0,
    output s1,
    output busy
  );

  // Requester/mux side: produces requests, observes grant and selects
  modport slave (
    output req,
    input  gnt,
    input  s0,
    input  s1,
    input  busy
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin arbiter with hold limit driving 4:1 mux selects
module mux_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  mux_rr_arbiter_if.master  bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q;
  logic [1:0]       own_q;
  logic [1:0]       ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       gnt_q;
  logic             s0_q;
  logic             s1_q;
  logic             busy_q;

  logic             win_vld_d;
  logic [1:0]       win_idx_d;
  logic             release_d;

  // Winner search: first requester at or after ptr, wrapping modulo 4.
  // ptr always equals own+1 while granted, so the same search serves both
  // the idle case and the release case.
  always_comb begin
    win_vld_d = 1'b0;
    win_idx_d = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      if (bus.req[ptr_q + 2'(k)]) begin
        win_vld_d = 1'b1;
        win_idx_d = ptr_q + 2'(k);
      end
    end
  end

  // Owner gives up the mux when it drops its request or its hold budget is spent
  always_comb begin
    release_d = !bus.req[own_q] || (cnt_q == CNT_W'(MAX_HOLD));
  end

  // Arbitration FSM with registered grant, selects and busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      own_q   <= 2'd0;
      ptr_q   <= 2'd0;
      cnt_q   <= '0;
      gnt_q   <= 4'b0000;
      s0_q    <= 1'b0;
      s1_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      if ((state_q == GRANT) && !release_d) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else if (win_vld_d) begin
        // New grant, or re-grant of a lone owner whose hold expired
        state_q <= GRANT;
        own_q   <= win_idx_d;
        ptr_q   <= win_idx_d + 2'd1;
        cnt_q   <= CNT_W'(1);
        gnt_q   <= 4'b0001 << win_idx_d;
        s0_q    <= win_idx_d[1];
        s1_q    <= win_idx_d[0];
        busy_q  <= 1'b1;
      end else begin
        // Nobody wants the mux; selects keep their last value
        state_q <= IDLE;
        cnt_q   <= '0;
        gnt_q   <= 4'b0000;
        busy_q  <= 1'b0;
      end
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.s0   = s0_q;
  assign bus.s1   = s1_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - scoreboard bench for mux_rr_arbiter with randomized requests
module tb_mux_rr_arbiter;

  localparam int MAX_HOLD = 8;

  typedef struct {
    logic [3:0] gnt;
    logic       s0;
    logic       s1;
    logic       busy;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t sb_q[$];

  // Reference model state: owner (-1 = idle), cycles held, next priority, last selected index
  int m_own;
  int m_held;
  int m_ptr;
  int m_sel;

  mux_rr_arbiter_if arb_if ();

  mux_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (arb_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_own  = -1;
    m_held = 0;
    m_ptr  = 0;
    m_sel  = 0;
  endtask

  // One clock edge of the arbitration rules, applied to the sampled request vector
  task automatic model_step(input logic [3:0] r, output exp_t e);
    int found;
    if (m_own >= 0 && r[m_own] && m_held < MAX_HOLD) begin
      m_held = m_held + 1;
    end else begin
      found = -1;
      for (int k = 0; k < 4; k++) begin
        if (found < 0 && r[(m_ptr + k) % 4]) found = (m_ptr + k) % 4;
      end
      if (found >= 0) begin
        m_own  = found;
        m_held = 1;
        m_ptr  = (found + 1) % 4;
        m_sel  = found;
      end else begin
        m_own  = -1;
        m_held = 0;
      end
    end
    e.gnt  = (m_own < 0) ? 4'b0000 : 4'(1 << m_own);
    e.s0   = m_sel[1];
    e.s1   = m_sel[0];
    e.busy = (m_own >= 0);
  endtask

  task automatic drive(input logic [3:0] r);
    exp_t e;
    @(negedge clk);
    arb_if.req = r;
    model_step(r, e);
    sb_q.push_back(e);
  endtask

  task automatic check_cleared(input string name);
    checks++;
    if ({arb_if.gnt, arb_if.s0, arb_if.s1, arb_if.busy} !== 7'b0) begin
      errors++;
      $display("FAIL %s: got gnt=%b s0=%b s1=%b busy=%b, want all zero",
               name, arb_if.gnt, arb_if.s0, arb_if.s1, arb_if.busy);
    end
  endtask

  // Monitor: after each active edge, pop the expected response and compare
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        checks++;
        if (arb_if.gnt !== e.gnt || arb_if.s0 !== e.s0 || arb_if.s1 !== e.s1 || arb_if.busy !== e.busy) begin
          errors++;
          $display("FAIL outputs @%0t: got gnt=%b s0=%b s1=%b busy=%b, want gnt=%b s0=%b s1=%b busy=%b",
                   $time, arb_if.gnt, arb_if.s0, arb_if.s1, arb_if.busy, e.gnt, e.s0, e.s1, e.busy);
        end
        checks++;
        if ((arb_if.gnt != 4'b0000) !== arb_if.busy || !$onehot0(arb_if.gnt)) begin
          errors++;
          $display("FAIL grant_busy @%0t: got gnt=%b busy=%b, want one-hot gnt iff busy",
                   $time, arb_if.gnt, arb_if.busy);
        end
      end
    end
  end

  initial begin
    logic [3:0] r;
    checks = 0;
    errors = 0;
    model_reset();
    arb_if.req = 4'b1111;
    rst = 1'b1;
    #2;
    check_cleared("reset_async");
    repeat (3) @(posedge clk);
    #1;
    check_cleared("reset_held");

    // Release reset with no requests so the first edge after it is idle
    @(negedge clk);
    arb_if.req = 4'b0000;
    rst = 1'b0;

    // Early release: owner 1 drops after 3 cycles, index 3 waiting
    repeat (3) drive(4'b0010);
    drive(4'b1000);
    drive(4'b0000);

    // Single requester on index 2, then drop: selects hold 1/0 while idle
    repeat (3) drive(4'b0100);
    repeat (2) drive(4'b0000);

    // Full contention: each owner keeps the mux exactly MAX_HOLD cycles
    repeat (5 * MAX_HOLD) drive(4'b1111);
    drive(4'b0000);

    // Lone requester past hold expiry: continuous re-grant
    repeat (20) drive(4'b0001);

    // Non-owner request changes during a grant have no effect
    drive(4'b0010);
    drive(4'b0011);
    drive(4'b1010);
    drive(4'b0110);
    drive(4'b0000);

    // Async reset mid-grant
    repeat (3) drive(4'b0100);
    @(posedge clk);
    #3;
    rst = 1'b1;
    arb_if.req = 4'b0000;
    #1;
    check_cleared("reset_mid_grant");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (10) drive(4'b1111);

    // Randomized traffic with sticky requests
    r = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) r = 4'($urandom);
      drive(r);
    end

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter that shares the single-bit 4:1 select multiplexer between four requesters. It grants the mux to at most one requester at a time and drives the mux select lines (s0, s1) to route that requester's input to the shared output. A programmable hold limit keeps any requester from owning the mux indefinitely. It sits directly in front of the 4:1 mux and is its only source of select values.

## Interface
- MAX_HOLD, default 8: maximum consecutive cycles one grant may last while other requesters wait; legal range 1 to 2^CNT_W − 1.
- CNT_W, default 4: width of the hold counter.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high; clears all state immediately.
- req  input  4  request vector; req[i] high means requester i wants the mux (i=0 selects a, 1 b, 2 c, 3 d).
- gnt  output  4  registered one-hot grant vector, or all zero when idle.
- s0  output  1  registered mux select, upper bit of the granted index.
- s1  output  1  registered mux select, lower bit of the granted index.
- busy  output  1  registered; high while a grant is active.

## Operation
- State: FSM {IDLE, GRANT}, owner index own[1:0], priority pointer ptr[1:0], hold counter cnt[CNT_W-1:0].
- Select encoding (fixed):
  - index 0 → s0=0, s1=0
  - index 1 → s0=0, s1=1
  - index 2 → s0=1, s1=0
  - index 3 → s0=1, s1=1
- Winner search is combinational. The winner is the first requester with req high, scanning ptr, ptr+1, ptr+2, ptr+3 modulo 4.
- IDLE:
  - If req≠0, go to GRANT: own=winner, gnt=1<<winner, s0/s1=winner, cnt=1, ptr=winner+1 (mod 4).
  - If req=0, stay in IDLE: gnt=0, s0/s1 hold their last value.
- GRANT, release condition = req[own]=0 OR (cnt==MAX_HOLD AND req[own]=1).
  - No release: hold gnt, s0, s1; cnt increments.
  - Release with winner available (winner search uses the updated ptr=own+1): switch directly to the new owner. No idle gap. cnt=1, ptr=winner+1.
  - Release with no requester at all: go to IDLE, gnt=0.
- Hold-expiry with the owner as the only requester: the owner is re-granted. gnt stays constant and cnt restarts at 1.
- Hold expiry with other requesters pending always moves the grant to a different requester.
- Changes on req bits of non-owners have no effect until the next release.
- busy=1 exactly when state=GRANT. gnt≠0 if and only if busy=1.

## Timing
- Reset values: gnt=4'b0000, s0=0, s1=0, busy=0, state=IDLE, ptr=0, cnt=0.
- Reset takes effect asynchronously, with no clock edge needed, including mid-grant.
- Grant latency: req sampled high at edge N gives gnt, s0, s1 and busy valid after edge N (1 cycle).
- Release latency: req[own] sampled low at edge N gives the new grant, or idle, after edge N.
- On a handover, gnt changes in a single cycle from one one-hot value to another, never through 0000. s0/s1 change on the same edge as gnt.
- Maximum continuous ownership under contention is MAX_HOLD cycles.
- With MAX_HOLD=1 and all four requesting, the grant rotates every cycle.
- Worst-case wait for a requester holding req high is 3·MAX_HOLD cycles.
- cnt never exceeds MAX_HOLD; no wrap-around is possible when CNT_W is legal.

## Test plan
- Reset: assert rst with req=1111 → gnt=0000, s0=0, s1=0, busy=0 immediately; these hold while rst=1.
- Single requester: req=0100 from cycle 0 → after the next edge gnt=0100, s0=1, s1=0, busy=1. Drop req → after one edge gnt=0000, busy=0, s0/s1 still 1/0.
- Full contention, MAX_HOLD=8: req=1111 held → gnt sequence 0001, 0010, 0100, 1000, 0001, each for exactly 8 cycles, with no 0000 cycle between grants.
- Early release: owner 1 (gnt=0010) drops req after 3 cycles with req=1000 → next edge gnt=1000, s0=1, s1=1, cnt=1.
- Lone requester hold expiry: req=0001 for 20 cycles → gnt=0001 continuously, busy never drops, cnt cycles 1..8.
- Async reset mid-grant: during gnt=0100, pulse rst between clock edges → outputs clear before the next edge. After release, req=1111 grants index 0 first (ptr=0).
